keypad_scan_4x4: RTL and testbench

// - Drives a 4x4 matrix keypad. Strobes the rows active-low one at a time and samples the four pulled-up column lines.
// - Debounces the result over whole scans and emits one key_valid pulse per press, with a 4-bit key code.
// - Replaces per-pin key inputs on boards with a matrix keypad. Its outputs feed the LED and control logic.

---
 rtl/keypad_scan_4x4_pkg.sv | 29 ++
 rtl/keypad_debounce_fsm.sv | 105 ++++++++++
 rtl/keypad_scan_4x4.sv | 88 ++++++++
 tb/tb_keypad_scan_4x4.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_4x4_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_scan_4x4_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_DEB   = 2'd3
    } kp_state_e;

    // Index of the lowest active-low column; 0 when none is low.
    function automatic logic [1:0] first_low(input logic [COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        if (!cols[0])      idx = 2'd0;
        else if (!cols[1]) idx = 2'd1;
        else if (!cols[2]) idx = 2'd2;
        else if (!cols[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [ROWS-1:0] row_strobe(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Whole-frame debounce: accepts a press or release after DEB_SCANS identical frames.
module keypad_debounce_fsm
    import keypad_scan_4x4_pkg::*;
#(
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_vld,
    input  logic       i_pressed,
    input  logic [3:0] i_code,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    output logic       o_key_held
);

    localparam int                CNT_W   = $clog2(DEB_SCANS + 1);
    localparam logic [CNT_W-1:0]  DEB_MAX = CNT_W'(DEB_SCANS);
    localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);

    kp_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_dcnt, w_dcnt_nxt, w_dcnt_inc;
    logic [3:0]       r_cand, w_cand_nxt;
    logic [3:0]       r_key_code, w_code_nxt;
    logic             r_key_valid, w_valid_nxt;
    logic             r_key_held;

    assign w_dcnt_inc = r_dcnt + ONE;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        if (i_frame_vld) begin
            case (r_state)
                ST_IDLE: if (i_pressed) begin
                    w_cand_nxt = i_code;
                    w_dcnt_nxt = ONE;
                    if (DEB_MAX == ONE) begin
                        w_state_nxt = ST_HELD;
                        w_valid_nxt = 1'b1;
                        w_code_nxt  = i_code;
                    end else begin
                        w_state_nxt = ST_PRESS_DEB;
                    end
                end
                ST_PRESS_DEB: begin
                    if (!i_pressed) begin
                        w_state_nxt = ST_IDLE;
                    end else if (i_code == r_cand) begin
                        w_dcnt_nxt = w_dcnt_inc;
                        if (w_dcnt_inc == DEB_MAX) begin
                            w_state_nxt = ST_HELD;
                            w_valid_nxt = 1'b1;
                            w_code_nxt  = r_cand;
                        end
                    end else begin
                        w_cand_nxt = i_code;
                        w_dcnt_nxt = ONE;
                    end
                end
                ST_HELD: if (!i_pressed) begin
                    w_dcnt_nxt  = ONE;
                    w_state_nxt = (DEB_MAX == ONE) ? ST_IDLE : ST_REL_DEB;
                end
                ST_REL_DEB: begin
                    if (i_pressed) begin
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_dcnt_nxt = w_dcnt_inc;
                        if (w_dcnt_inc == DEB_MAX) w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dcnt      <= '0;
            r_cand      <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_cand      <= w_cand_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_held  <= (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REL_DEB);
        end
    end

    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;
    assign o_key_held  = r_key_held;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: row strobing, column sync, frame build, debounced key events.
module keypad_scan_4x4
    import keypad_scan_4x4_pkg::*;
#(
    parameter logic [19:0] SCAN_DIV  = 20'd9_999,
    parameter int          DEB_SCANS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic            key_valid,
    output logic [3:0]      key_code,
    output logic            key_held
);

    logic [COLS-1:0] r_sync1, r_sync2;
    logic [19:0]     r_slot_cnt;
    logic [1:0]      r_row_idx;
    logic [ROWS-1:0] r_row_out;
    logic            r_acc_pressed;
    logic [3:0]      r_acc_code;

    logic            w_tick, w_row_hit, w_frame_vld, w_frame_pressed;
    logic [3:0]      w_row_code, w_frame_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_slot_cnt == SCAN_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= 20'd0;
            r_row_idx  <= 2'd0;
            r_row_out  <= row_strobe(2'd0);
        end else if (w_tick) begin
            r_slot_cnt <= 20'd0;
            r_row_idx  <= r_row_idx + 2'd1;
            r_row_out  <= row_strobe(r_row_idx + 2'd1);
        end else begin
            r_slot_cnt <= r_slot_cnt + 20'd1;
        end
    end

    // Lowest row wins: once a row has hit, later rows in the same scan are ignored.
    assign w_row_hit       = ~&r_sync2;
    assign w_row_code      = {r_row_idx, first_low(r_sync2)};
    assign w_frame_vld     = w_tick && (r_row_idx == 2'd3);
    assign w_frame_pressed = r_acc_pressed | w_row_hit;
    assign w_frame_code    = r_acc_pressed ? r_acc_code : w_row_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_pressed <= 1'b0;
            r_acc_code    <= 4'd0;
        end else if (w_frame_vld) begin
            r_acc_pressed <= 1'b0;
            r_acc_code    <= 4'd0;
        end else if (w_tick && !r_acc_pressed && w_row_hit) begin
            r_acc_pressed <= 1'b1;
            r_acc_code    <= w_row_code;
        end
    end

    keypad_debounce_fsm #(
        .DEB_SCANS (DEB_SCANS)
    ) u_deb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_frame_vld (w_frame_vld),
        .i_pressed   (w_frame_pressed),
        .i_code      (w_frame_code),
        .o_key_valid (key_valid),
        .o_key_code  (key_code),
        .o_key_held  (key_held)
    );

    assign row_out = r_row_out;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with a behavioural matrix keypad model.
module tb_keypad_scan_4x4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  col_in, row_out, key_code;
    logic        key_valid, key_held;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulse_cnt = 0;
    logic [3:0]  last_code = 4'd0;

    always #5 clk = ~clk;

    keypad_scan_4x4 #(
        .SCAN_DIV  (20'd9),
        .DEB_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    // A pressed key pulls its column low while its row strobe is low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulse_cnt++;
            last_code = key_code;
        end
    end

    task automatic wait_frame_start(output bit ok);
        bit seen3;
        seen3 = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (row_out == 4'b0111) seen3 = 1'b1;
            else if (seen3 && row_out == 4'b1110) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic wait_release(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!key_held) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_rows [4];
        exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        keys  = 16'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({row_out, key_valid, key_code, key_held} !== {4'b1110, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got row=%b v=%b code=%0d held=%b want row=1110 v=0 code=0 held=0",
                     row_out, key_valid, key_code, key_held);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (row_out !== exp_rows[k % 4]) begin
                n_fail++;
                $display("FAIL row_cycle[%0d] got %b want %b", k, row_out, exp_rows[k % 4]);
            end
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_idle;
        int pc0;
        pc0 = pulse_cnt;
        repeat (200) @(negedge clk);
        n_checks++;
        if (pulse_cnt - pc0 !== 0 || key_code !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_no_pulse got pulses=%0d code=%0d want 0 0", pulse_cnt - pc0, key_code);
        end
    endtask

    task automatic test_single_press;
        bit ok;
        int lat, pc0;
        pc0 = pulse_cnt;
        wait_frame_start(ok);
        keys[6] = 1'b1;
        wait_valid(200, lat);
        n_checks++;
        if (!ok || lat !== 120) begin
            n_fail++;
            $display("FAIL press_latency got %0d (sync=%0d) want 120", lat, ok);
        end
        n_checks++;
        if (key_code !== 4'd6 || key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL press_code got code=%0d held=%b want 6 1", key_code, key_held);
        end
        repeat (150) @(negedge clk);
        n_checks++;
        if (pulse_cnt - pc0 !== 1 || key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL press_single got pulses=%0d held=%b want 1 1", pulse_cnt - pc0, key_held);
        end
        wait_frame_start(ok);
        keys = 16'h0;
        wait_release(200, lat);
        n_checks++;
        if (!ok || lat !== 120) begin
            n_fail++;
            $display("FAIL release_latency got %0d want 120", lat);
        end
    endtask

    task automatic test_bounce;
        int pc0, lat;
        pc0 = pulse_cnt;
        for (int i = 0; i < 80; i++) begin
            if (i % 7 == 0) keys[6] = ~keys[6];
            @(negedge clk);
        end
        keys[6] = 1'b1;
        repeat (250) @(negedge clk);
        n_checks++;
        if (pulse_cnt - pc0 !== 1 || last_code !== 4'd6 || key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce got pulses=%0d code=%0d held=%b want 1 6 1",
                     pulse_cnt - pc0, last_code, key_held);
        end
        keys = 16'h0;
        wait_release(250, lat);
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL bounce_release got timeout want key_held=0");
        end
    endtask

    task automatic test_two_keys;
        int pc0, lat;
        pc0 = pulse_cnt;
        keys[6] = 1'b1;
        keys[9] = 1'b1;
        wait_valid(200, lat);
        n_checks++;
        if (lat < 0 || key_code !== 4'd6) begin
            n_fail++;
            $display("FAIL two_keys_priority got lat=%0d code=%0d want code 6", lat, key_code);
        end
        keys[6] = 1'b0;
        repeat (200) @(negedge clk);
        n_checks++;
        if (pulse_cnt - pc0 !== 1 || key_held !== 1'b1 || key_code !== 4'd6) begin
            n_fail++;
            $display("FAIL two_keys_rollover got pulses=%0d held=%b code=%0d want 1 1 6",
                     pulse_cnt - pc0, key_held, key_code);
        end
        keys = 16'h0;
        wait_release(250, lat);
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL two_keys_release got timeout want key_held=0");
        end
    endtask

    task automatic test_glitch;
        int pc1, lat;
        keys[6] = 1'b1;
        wait_valid(200, lat);
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL glitch_accept got timeout want key_valid");
        end
        repeat (20) @(negedge clk);
        pc1 = pulse_cnt;
        keys = 16'h0;
        repeat (65) @(negedge clk);
        keys[6] = 1'b1;
        repeat (40) @(negedge clk);
        keys[6] = 1'b0;
        n_checks++;
        if (key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_held got %b want 1", key_held);
        end
        wait_release(300, lat);
        n_checks++;
        if (lat < 80 || pulse_cnt !== pc1) begin
            n_fail++;
            $display("FAIL glitch_release got lat=%0d extra_pulses=%0d want lat>=80 extra=0",
                     lat, pulse_cnt - pc1);
        end
    endtask

    task automatic test_reset_mid;
        bit ok0, ok1, ok2;
        int pc0, lat;
        wait_frame_start(ok0);
        keys[6] = 1'b1;
        pc0 = pulse_cnt;
        wait_frame_start(ok1);
        wait_frame_start(ok2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (!(ok0 && ok1 && ok2) || pulse_cnt !== pc0 ||
            {row_out, key_valid, key_code, key_held} !== {4'b1110, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset got row=%b v=%b code=%0d held=%b pulses=%0d want 1110 0 0 0 0",
                     row_out, key_valid, key_code, key_held, pulse_cnt - pc0);
        end
        rst_n = 1'b1;
        wait_valid(200, lat);
        n_checks++;
        if (lat !== 120 || key_code !== 4'd6) begin
            n_fail++;
            $display("FAIL mid_reset_reaccept got lat=%0d code=%0d want 120 6", lat, key_code);
        end
        keys = 16'h0;
        wait_release(250, lat);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_glitch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
